// File: rtl/arb_mem_pkg.sv
// Shared types and page map for the data-memory arbiter.
package arb_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StLock1
  } state_e;

  typedef enum logic [1:0] {
    FltNone,
    FltUnmapped,
    FltRomWr
  } fault_e;

  // Control part of an in-flight command; address and data are held alongside it.
  typedef struct packed {
    logic   valid;
    logic   port;
    logic   we;
    fault_e fault;
  } cmd_t;

  localparam int unsigned PageRam1Lo = 0;
  localparam int unsigned PageRam1Hi = 1;
  localparam int unsigned PageRam2Lo = 2;
  localparam int unsigned PageRam2Hi = 3;
  localparam int unsigned PageRom    = 4;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin arbiter; mask0 blocks port 0 while port 1 holds a lock.
module arb_rr2 (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic mask0,
  output logic gnt0,
  output logic gnt1
);

  logic ptr_q;  // 1: port 1 wins a tie
  logic req0_eff;

  assign req0_eff = req0 & ~mask0;
  assign gnt0     = ~reset & req0_eff & (~req1 | ~ptr_q);
  assign gnt1     = ~reset & req1 & (~req0_eff | ptr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (gnt0) begin
      ptr_q <= 1'b1;
    end else if (gnt1) begin
      ptr_q <= 1'b0;
    end
  end

endmodule

// File: rtl/arbitro_memoria_datos.sv
// Two-port arbiter/sequencer for the banked data memory.
// Define ARB_ROM_WP_EN to turn writes to the ROM page into faults.
module arbitro_memoria_datos
  import arb_mem_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_PAGE = 4,
  parameter int unsigned ROM_PAGE = PageRom
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              stall0,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              err0,
  output logic              err1,
  output logic              mem_escr,
  output logic              mem_leer,
  output logic [ADDR_W-1:0] mem_direc,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout
);

  localparam int unsigned PageW = ADDR_W - 8;

`ifdef ARB_ROM_WP_EN
  localparam bit RomWp = 1'b1;
`else
  localparam bit RomWp = 1'b0;
`endif

  state_e            state_q;
  cmd_t              cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [PageW-1:0]  sel_page;
  fault_e            sel_fault;
  logic              drive;
  logic              good;

  arb_rr2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .mask0 (state_q == StLock1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign any_gnt = gnt0 | gnt1;
  assign stall0  = req0 & ~gnt0;

  always_comb begin
    sel_we    = gnt1 ? we1 : we0;
    sel_addr  = gnt1 ? addr1 : addr0;
    sel_wdata = gnt1 ? wdata1 : wdata0;
    sel_page  = sel_addr[ADDR_W-1:8];
    sel_fault = FltNone;
    if (sel_page > PageW'(MAX_PAGE)) begin
      sel_fault = FltUnmapped;
    end else if (RomWp && sel_we && (sel_page == PageW'(ROM_PAGE))) begin
      sel_fault = FltRomWr;
    end
  end

  // Memory is driven straight from the command register in the cycle after accept.
  assign drive      = cmd_q.valid && (cmd_q.fault == FltNone);
  assign good       = drive;
  assign mem_leer   = drive & ~cmd_q.we;
  assign mem_escr   = drive & cmd_q.we;
  assign mem_direc  = drive ? addr_q : '0;
  assign mem_datain = (drive && cmd_q.we) ? wdata_q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rdata   <= '0;
    end else begin
      cmd_q.valid <= any_gnt;
      if (any_gnt) begin
        cmd_q.port  <= gnt1;
        cmd_q.we    <= sel_we;
        cmd_q.fault <= sel_fault;
        addr_q      <= sel_addr;
        wdata_q     <= sel_wdata;
      end

      rvalid0 <= good && !cmd_q.we && !cmd_q.port;
      rvalid1 <= good && !cmd_q.we && cmd_q.port;
      err0    <= cmd_q.valid && (cmd_q.fault != FltNone) && !cmd_q.port;
      err1    <= cmd_q.valid && (cmd_q.fault != FltNone) && cmd_q.port;
      if (good && !cmd_q.we) begin
        rdata <= mem_dataout;
      end

      if (gnt1 && lock1) begin
        state_q <= StLock1;
      end else if ((state_q == StLock1) && lock1) begin
        state_q <= StLock1;
      end else if (any_gnt) begin
        state_q <= StBusy;
      end else begin
        state_q <= StIdle;
      end
    end
  end

  // Requesters must hold a request until it is granted.
  req0_held: assert property (@(posedge clk) disable iff (reset) (req0 && !gnt0) |=> req0);
  req1_held: assert property (@(posedge clk) disable iff (reset) (req1 && !gnt1) |=> req1);

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Bench for arbitro_memoria_datos: directed scenarios plus random traffic against a cycle model.
module tb_arbitro_memoria_datos;
  import arb_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1, lock1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, stall0, rvalid0, rvalid1, err0, err1, mem_escr, mem_leer;
  logic [31:0] rdata, mem_direc, mem_datain, mem_dataout;

  int unsigned checks = 0;
  int unsigned errors = 0;

`ifdef ARB_ROM_WP_EN
  localparam bit Wp = 1'b1;
`else
  localparam bit Wp = 1'b0;
`endif

  arbitro_memoria_datos dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .stall0(stall0), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .err0(err0), .err1(err1), .mem_escr(mem_escr), .mem_leer(mem_leer),
    .mem_direc(mem_direc), .mem_datain(mem_datain), .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  // Memory model: either a forced word or an address hash.
  logic        fixed_en = 1'b0;
  logic [31:0] fixed_val = 32'h0;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always_comb mem_dataout = fixed_en ? fixed_val : hash(mem_direc);

  // Reference model state
  bit          m_prio, m_lock;
  bit          s1_v, s1_port, s1_we, s1_flt;
  logic [31:0] s1_addr, s1_wdata;
  bit          e_rv0, e_rv1, e_er0, e_er1;
  logic [31:0] e_rdata;
  bit          last_g0, last_g1;

  function automatic bit is_fault(input logic [31:0] a, input bit we);
    logic [23:0] page;
    page = a[31:8];
    return (page > 24'd4) || (Wp && we && page == 24'd4);
  endfunction

  task automatic model_reset();
    m_prio = 0; m_lock = 0; s1_v = 0; s1_port = 0; s1_we = 0; s1_flt = 0;
    s1_addr = '0; s1_wdata = '0;
    e_rv0 = 0; e_rv1 = 0; e_er0 = 0; e_er1 = 0; e_rdata = '0;
    last_g0 = 0; last_g1 = 0;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic run_cycle();
    bit g0, g1, str;
    @(negedge clk);
    if (m_lock) begin
      g0 = 0; g1 = req1;
    end else if (req0 && req1) begin
      g0 = (m_prio == 0); g1 = !g0;
    end else begin
      g0 = req0; g1 = req1;
    end
    chk_bit("gnt0", gnt0, g0);
    chk_bit("gnt1", gnt1, g1);
    chk_bit("stall0", stall0, req0 && !g0);
    str = s1_v && !s1_flt;
    chk_bit("mem_leer", mem_leer, str && !s1_we);
    chk_bit("mem_escr", mem_escr, str && s1_we);
    if (str) chk_word("mem_direc", mem_direc, s1_addr);
    if (str && s1_we) chk_word("mem_datain", mem_datain, s1_wdata);
    chk_bit("rvalid0", rvalid0, e_rv0);
    chk_bit("rvalid1", rvalid1, e_rv1);
    chk_bit("err0", err0, e_er0);
    chk_bit("err1", err1, e_er1);
    chk_word("rdata", rdata, e_rdata);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      e_rv0 = str && !s1_we && !s1_port;
      e_rv1 = str && !s1_we && s1_port;
      e_er0 = s1_v && s1_flt && !s1_port;
      e_er1 = s1_v && s1_flt && s1_port;
      if (str && !s1_we) e_rdata = fixed_en ? fixed_val : hash(s1_addr);
      s1_v     = g0 || g1;
      s1_port  = g1;
      s1_we    = g1 ? we1 : we0;
      s1_addr  = g1 ? addr1 : addr0;
      s1_wdata = g1 ? wdata1 : wdata0;
      s1_flt   = is_fault(s1_addr, s1_we);
      if (g0) m_prio = 1;
      else if (g1) m_prio = 0;
      m_lock = lock1 && (g1 || m_lock);
      last_g0 = g0; last_g1 = g1;
    end
    #1;
  endtask

  // Drop granted requests, keep pending ones until granted, then flush the pipeline.
  task automatic settle();
    lock1 = 0;
    for (int i = 0; i < 8; i++) begin
      if (last_g0) req0 = 0;
      if (last_g1) req1 = 0;
      if (!req0 && !req1) break;
      run_cycle();
    end
    run_cycle();
    run_cycle();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {$urandom_range(0, 6), 8'h00} | ($urandom & 32'hFF);
    if ($urandom_range(0, 15) == 0) a = $urandom;
    return a;
  endfunction

  initial begin
    reset = 1; req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; lock1 = 0;
    model_reset();
    run_cycle();
    run_cycle();
    reset = 0;
    run_cycle();

    // Single read at 0x104 returning a known word
    fixed_en = 1; fixed_val = 32'hCAFE_0001;
    req0 = 1; we0 = 0; addr0 = 32'h104;
    run_cycle();
    req0 = 0;
    run_cycle();
    run_cycle();
    chk_word("read_0x104_rdata", rdata, 32'hCAFE_0001);
    fixed_en = 0;
    run_cycle();

    // Both ports requesting continuously
    req0 = 1; we0 = 0; addr0 = 32'h010;
    req1 = 1; we1 = 0; addr1 = 32'h020;
    repeat (4) run_cycle();
    settle();

    // Locked burst of three writes from port 1 while port 0 waits
    req1 = 1; lock1 = 1; we1 = 1; addr1 = 32'h200; wdata1 = 32'hA0;
    run_cycle();
    req0 = 1; we0 = 0; addr0 = 32'h300;
    addr1 = 32'h201; wdata1 = 32'hA1;
    run_cycle();
    addr1 = 32'h202; wdata1 = 32'hA2;
    run_cycle();
    req1 = 0; lock1 = 0;
    run_cycle();
    run_cycle();
    settle();

    // Unmapped read
    req0 = 1; we0 = 0; addr0 = 32'h500;
    run_cycle();
    req0 = 0;
    run_cycle();
    run_cycle();
    run_cycle();

    // Write to the ROM page
    req0 = 1; we0 = 1; addr0 = 32'h410; wdata0 = 32'h1234_5678;
    run_cycle();
    req0 = 0;
    run_cycle();
    run_cycle();
    run_cycle();

    // Reset while a read is on the memory bus
    req0 = 1; we0 = 0; addr0 = 32'h108;
    run_cycle();
    req0 = 0; reset = 1;
    run_cycle();
    reset = 0;
    run_cycle();
    chk_bit("fsm_idle_after_reset", dut.state_q == StIdle, 1'b1);
    run_cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (!req0 || last_g0) begin
        req0 = ($urandom_range(0, 3) != 0); we0 = $urandom; addr0 = rand_addr(); wdata0 = $urandom;
      end
      if (!req1 || last_g1) begin
        req1 = ($urandom_range(0, 2) == 0); we1 = $urandom; addr1 = rand_addr(); wdata1 = $urandom;
      end
      lock1 = ($urandom_range(0, 4) == 0);
      run_cycle();
    end
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
